evt_ce_gen: RTL and testbench

- Upstream feeder for the team's clock-enabled synchronous-reset counter.
- Converts an asynchronous event line into single-cycle count-enable (CE) strobes, with a programmable dead time (holdoff) after each strobe.
- Issues a one-cycle synchronous clear (SRST) to the counter on request.
- Counts events dropped during holdoff. Optional TMR build for radiation-exposed front-end placement.

---
 rtl/evt_ce_gen.sv | 145 ++++++++++++++
 tb/tb_evt_ce_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/evt_ce_gen.sv
// Event front end for the clock-enabled counter: turns an asynchronous event line into
// single-cycle CE strobes with programmable holdoff, issues SRST on request, counts lost events.
module evt_ce_gen #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLDOFF_W   = 4,
   parameter int TMR         = 0
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 EVT_IN,
   input  logic                 ENA,
   input  logic [HOLDOFF_W-1:0] HOLDOFF,
   input  logic                 CLR_REQ,
   output logic                 CE,
   output logic                 SRST,
   output logic                 BUSY,
   output logic [7:0]           LOST_CNT
);

   localparam int NC = (TMR != 0) ? 3 : 1;
   localparam logic [HOLDOFF_W-1:0] CNT_ONE = HOLDOFF_W'(1'b1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      CLEAR = 2'd2
   } state_t;

   typedef struct packed {
      logic [SYNC_STAGES-1:0] sync;
      logic                   hist;
      logic [SYNC_STAGES-1:0] vld;
      logic                   armed;
      state_t                 state;
      logic [HOLDOFF_W-1:0]   cnt;
      logic [7:0]             lost;
      logic                   ce;
      logic                   srst;
      logic                   busy;
   } regs_t;

   localparam int RW = $bits(regs_t);

   function automatic logic [RW-1:0] maj3(input logic [RW-1:0] a,
                                          input logic [RW-1:0] b,
                                          input logic [RW-1:0] c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   regs_t [NC-1:0] cp_r;
   regs_t          vt_s;
   logic           edge_s;
   logic           evt_ok_s;

   // With TMR every copy is read only through the vote, so a single upset never reaches logic.
   generate
      if (TMR != 0) begin : g_vote
         assign vt_s = regs_t'(maj3(cp_r[0], cp_r[1], cp_r[2]));
      end else begin : g_plain
         assign vt_s = cp_r[0];
      end
   endgenerate

   // An edge only counts once the sync output has been seen low after reset (armed).
   assign edge_s   = vt_s.sync[SYNC_STAGES-1] & ~vt_s.hist & vt_s.armed;
   assign evt_ok_s = edge_s & ENA;

   // State update: every copy loads the same next value computed from the voted state.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cp_r <= '0;
      end else begin
         for (int i = 0; i < NC; i++) begin
            cp_r[i].sync  <= {vt_s.sync[SYNC_STAGES-2:0], EVT_IN};
            cp_r[i].hist  <= vt_s.sync[SYNC_STAGES-1];
            cp_r[i].vld   <= {vt_s.vld[SYNC_STAGES-2:0], 1'b1};
            cp_r[i].armed <= vt_s.armed | (vt_s.vld[SYNC_STAGES-1] & ~vt_s.sync[SYNC_STAGES-1]);
            cp_r[i].ce    <= 1'b0;
            cp_r[i].srst  <= 1'b0;
            cp_r[i].cnt   <= vt_s.cnt;
            cp_r[i].lost  <= vt_s.lost;
            case (vt_s.state)
               IDLE: begin
                  if (CLR_REQ) begin
                     cp_r[i].state <= CLEAR;
                     cp_r[i].srst  <= 1'b1;
                     cp_r[i].lost  <= 8'd0;
                     cp_r[i].busy  <= 1'b0;
                  end else if (evt_ok_s) begin
                     cp_r[i].ce  <= 1'b1;
                     cp_r[i].cnt <= HOLDOFF;
                     if (HOLDOFF != '0) begin
                        cp_r[i].state <= HOLD;
                        cp_r[i].busy  <= 1'b1;
                     end else begin
                        cp_r[i].state <= IDLE;
                        cp_r[i].busy  <= 1'b0;
                     end
                  end else begin
                     cp_r[i].state <= IDLE;
                     cp_r[i].busy  <= 1'b0;
                  end
               end
               HOLD: begin
                  if (CLR_REQ) begin
                     cp_r[i].state <= CLEAR;
                     cp_r[i].srst  <= 1'b1;
                     cp_r[i].lost  <= 8'd0;
                     cp_r[i].busy  <= 1'b0;
                  end else begin
                     if (evt_ok_s && (vt_s.lost != 8'hFF)) begin
                        cp_r[i].lost <= vt_s.lost + 8'd1;
                     end else begin
                        cp_r[i].lost <= vt_s.lost;
                     end
                     cp_r[i].cnt <= vt_s.cnt - CNT_ONE;
                     // cnt of 0 cannot occur legitimately; leaving on it bounds a corrupted count
                     if (vt_s.cnt <= CNT_ONE) begin
                        cp_r[i].state <= IDLE;
                        cp_r[i].busy  <= 1'b0;
                     end else begin
                        cp_r[i].state <= HOLD;
                        cp_r[i].busy  <= 1'b1;
                     end
                  end
               end
               CLEAR: begin
                  cp_r[i].state <= IDLE;
                  cp_r[i].busy  <= 1'b0;
               end
               default: begin
                  cp_r[i].state <= IDLE;
                  cp_r[i].busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign CE       = vt_s.ce;
   assign SRST     = vt_s.srst;
   assign BUSY     = vt_s.busy;
   assign LOST_CNT = vt_s.lost;

endmodule

// File: tb/tb_evt_ce_gen.sv
// Bench for evt_ce_gen: plain and TMR builds driven in lockstep and compared every cycle
// against a sample-history / remaining-cycles reference model.
module tb_evt_ce_gen;

   localparam int S  = 2;
   localparam int HW = 4;
   localparam int RW = 2 * S + HW + 15;

   logic          CLK     = 1'b0;
   logic          RST     = 1'b1;
   logic          EVT_IN  = 1'b0;
   logic          ENA     = 1'b1;
   logic          CLR_REQ = 1'b0;
   logic [HW-1:0] HOLDOFF = 4'd3;

   logic       ce0, srst0, busy0, ce1, srst1, busy1;
   logic [7:0] lost0, lost1;

   int errors = 0;
   int checks = 0;
   int ce_seen0 = 0;
   int ce_seen1 = 0;
   int b0, b1, lb;

   // reference model state
   int  p;
   bit  e_hist [0:7];
   bit  m_ce, m_srst, m_busy, m_clear;
   int  m_lost, m_hold;

   logic [3*RW-1:0] upset_v;

   always #5 CLK = ~CLK;

   evt_ce_gen #(.SYNC_STAGES(S), .HOLDOFF_W(HW), .TMR(0)) dut0 (
      .CLK(CLK), .RST(RST), .EVT_IN(EVT_IN), .ENA(ENA), .HOLDOFF(HOLDOFF), .CLR_REQ(CLR_REQ),
      .CE(ce0), .SRST(srst0), .BUSY(busy0), .LOST_CNT(lost0));

   evt_ce_gen #(.SYNC_STAGES(S), .HOLDOFF_W(HW), .TMR(1)) dut1 (
      .CLK(CLK), .RST(RST), .EVT_IN(EVT_IN), .ENA(ENA), .HOLDOFF(HOLDOFF), .CLR_REQ(CLR_REQ),
      .CE(ce1), .SRST(srst1), .BUSY(busy1), .LOST_CNT(lost1));

   task automatic model_reset();
      p = 0;
      for (int k = 0; k < 8; k++) e_hist[k] = 1'b0;
      m_ce = 1'b0; m_srst = 1'b0; m_busy = 1'b0; m_clear = 1'b0;
      m_lost = 0; m_hold = 0;
   endtask

   // An event is a 0->1 in the samples taken since reset; it is acted on S clocks after its sample.
   task automatic model_step();
      bit ev;
      if (p < 1000) p++;
      for (int k = 7; k > 0; k--) e_hist[k] = e_hist[k-1];
      e_hist[0] = EVT_IN;
      ev = (p >= S + 2) && e_hist[S] && !e_hist[S+1];
      m_ce = 1'b0;
      m_srst = 1'b0;
      if (m_clear) begin
         m_clear = 1'b0;
         m_busy = 1'b0;
      end else if (CLR_REQ) begin
         m_clear = 1'b1; m_srst = 1'b1; m_lost = 0; m_hold = 0; m_busy = 1'b0;
      end else if (m_hold > 0) begin
         if (ev && ENA) m_lost = (m_lost < 255) ? m_lost + 1 : 255;
         m_hold = m_hold - 1;
         m_busy = (m_hold > 0);
      end else if (ev && ENA) begin
         m_ce = 1'b1;
         m_hold = int'(HOLDOFF);
         m_busy = (HOLDOFF != 4'd0);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("ce_plain",   {31'd0, ce0},   {31'd0, m_ce});
      chk("srst_plain", {31'd0, srst0}, {31'd0, m_srst});
      chk("busy_plain", {31'd0, busy0}, {31'd0, m_busy});
      chk("lost_plain", {24'd0, lost0}, m_lost);
      chk("ce_tmr",     {31'd0, ce1},   {31'd0, m_ce});
      chk("srst_tmr",   {31'd0, srst1}, {31'd0, m_srst});
      chk("busy_tmr",   {31'd0, busy1}, {31'd0, m_busy});
      chk("lost_tmr",   {24'd0, lost1}, m_lost);
      if (ce0 === 1'b1) ce_seen0++;
      if (ce1 === 1'b1) ce_seen1++;
   endtask

   task automatic tick();
      @(posedge CLK);
      if (RST) model_reset();
      else model_step();
      @(negedge CLK);
      check_all();
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic pulse(input int hi, input int lo);
      EVT_IN = 1'b1;
      ticks(hi);
      EVT_IN = 1'b0;
      ticks(lo);
   endtask

   // Corrupt every bit of one TMR copy, then let the design's own update take over again.
   task automatic upset(input int copy);
      upset_v = dut1.cp_r;
      upset_v[copy*RW +: RW] = ~upset_v[copy*RW +: RW];
      force dut1.cp_r = upset_v;
      #1;
      release dut1.cp_r;
   endtask

   initial begin
      model_reset();
      ticks(2);
      RST = 1'b0;
      ticks(4);

      // single pulse, HOLDOFF=3
      HOLDOFF = 4'd3; b0 = ce_seen0; b1 = ce_seen1;
      pulse(5, 8);
      chk("single_ce_plain", ce_seen0 - b0, 1);
      chk("single_ce_tmr", ce_seen1 - b1, 1);
      chk("single_lost", {24'd0, lost0}, 0);

      // holdoff loss, HOLDOFF=6
      HOLDOFF = 4'd6; b0 = ce_seen0;
      pulse(1, 2);
      pulse(1, 6);
      chk("holdoff_lost", {24'd0, lost0}, 1);
      pulse(1, 15);
      chk("holdoff_ce", ce_seen0 - b0, 2);

      // back-to-back with HOLDOFF=0
      HOLDOFF = 4'd0; b0 = ce_seen0; b1 = ce_seen1;
      repeat (10) pulse(1, 1);
      ticks(4);
      chk("b2b_ce_plain", ce_seen0 - b0, 10);
      chk("b2b_ce_tmr", ce_seen1 - b1, 10);

      // saturation then clear
      HOLDOFF = 4'd15;
      repeat (350) pulse(1, 1);
      ticks(20);
      chk("sat_lost_plain", {24'd0, lost0}, 255);
      chk("sat_lost_tmr", {24'd0, lost1}, 255);
      CLR_REQ = 1'b1;
      tick();
      CLR_REQ = 1'b0;
      chk("clr_srst", {31'd0, srst0}, 1);
      chk("clr_lost", {24'd0, lost0}, 0);
      chk("clr_ce", {31'd0, ce0}, 0);
      ticks(3);

      // clear request coincident with an edge in IDLE
      HOLDOFF = 4'd3; ticks(4); b0 = ce_seen0;
      EVT_IN = 1'b1;
      ticks(S);
      CLR_REQ = 1'b1;
      tick();
      CLR_REQ = 1'b0; EVT_IN = 1'b0;
      chk("prio_srst", {31'd0, srst0}, 1);
      chk("prio_ce", {31'd0, ce0}, 0);
      chk("prio_lost", {24'd0, lost0}, 0);
      ticks(4);
      chk("prio_ce_count", ce_seen0 - b0, 0);

      // clear request during HOLD, then a normal event
      HOLDOFF = 4'd8; b0 = ce_seen0;
      pulse(1, S + 3);
      CLR_REQ = 1'b1;
      tick();
      CLR_REQ = 1'b0;
      chk("hold_clr_busy", {31'd0, busy0}, 0);
      chk("hold_clr_srst", {31'd0, srst0}, 1);
      ticks(3);
      pulse(1, S + 2);
      chk("hold_clr_ce", ce_seen0 - b0, 2);
      ticks(10);

      // ENA=0: edges neither strobe nor count as lost
      HOLDOFF = 4'd8; b0 = ce_seen0;
      pulse(1, S);
      lb = m_lost;
      ENA = 1'b0;
      repeat (3) pulse(1, 1);
      ticks(3);
      ENA = 1'b1;
      ticks(10);
      chk("ena_lost", {24'd0, lost0}, lb);
      chk("ena_ce", ce_seen0 - b0, 1);

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         if ((n % 50) == 0) HOLDOFF = 4'($urandom_range(0, 15));
         EVT_IN  = 1'($urandom_range(0, 1));
         ENA     = ($urandom_range(0, 7) != 0);
         CLR_REQ = ($urandom_range(0, 29) == 0);
         tick();
      end
      EVT_IN = 1'b0; CLR_REQ = 1'b0; ENA = 1'b1;
      ticks(20);

      // TMR copy upsets mid-HOLD; a second copy is hit only after the first has had time to heal
      HOLDOFF = 4'd10; b1 = ce_seen1;
      pulse(1, S + 2);
      upset(1);
      ticks(2);
      upset(2);
      ticks(12);
      chk("tmr_upset_ce", ce_seen1 - b1, 1);

      // asynchronous reset mid-HOLD
      HOLDOFF = 4'd12;
      pulse(1, S + 3);
      #2 RST = 1'b1;
      #1;
      chk("arst_ce_plain", {31'd0, ce0}, 0);
      chk("arst_busy_plain", {31'd0, busy0}, 0);
      chk("arst_lost_plain", {24'd0, lost0}, 0);
      chk("arst_busy_tmr", {31'd0, busy1}, 0);
      chk("arst_srst_tmr", {31'd0, srst1}, 0);
      model_reset();
      EVT_IN = 1'b1;
      ticks(2);
      RST = 1'b0;
      b0 = ce_seen0; b1 = ce_seen1;
      ticks(10);
      chk("held_high_ce_plain", ce_seen0 - b0, 0);
      chk("held_high_ce_tmr", ce_seen1 - b1, 0);
      EVT_IN = 1'b0;
      ticks(4);
      pulse(1, S + 3);
      chk("rearm_ce", ce_seen0 - b0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
